// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory/IO controller: word width,
// memory-mapped I/O register addresses and the access FSM encoding.
package lc3_mem_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Start of I/O space; everything at or above it is decoded as I/O.
  localparam word_t IO_BASE_DEF = 16'hFE00;

  localparam word_t KBSR_ADDR = 16'hFE00;
  localparam word_t KBDR_ADDR = 16'hFE02;
  localparam word_t DSR_ADDR  = 16'hFE04;
  localparam word_t DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    IO     = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard and display device registers with their status flags and the
// 16-bit read mux seen by the LC-3 when it addresses I/O space.
module lc3_io_regs
  import lc3_mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       wr_en,
  input  word_t      addr,
  input  logic [7:0] wdata,
  output word_t      rdata,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  input  logic       disp_ack
);

  logic       kb_full;
  logic       kb_ovr;
  logic [7:0] kbdr;
  logic       kbdr_rd;
  logic       ddr_wr;
  logic       dsr_rdy;

  assign kbdr_rd = rd_en && (addr == KBDR_ADDR);
  assign ddr_wr  = wr_en && (addr == DDR_ADDR);
  // The display is ready exactly when no character is waiting to be consumed.
  assign dsr_rdy = !disp_valid;

  // Keyboard: latch a char when empty, flag overrun when full; a KBDR read
  // empties the buffer, but a char arriving in that same cycle still lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kb_full <= 1'b0;
      kb_ovr  <= 1'b0;
      kbdr    <= '0;
    end else begin
      if (kbdr_rd) begin
        kb_full <= 1'b0;
        kb_ovr  <= 1'b0;
      end
      if (kb_valid) begin
        if (kb_full && !kbdr_rd) begin
          kb_ovr <= 1'b1;
        end else begin
          kbdr    <= kb_data;
          kb_full <= 1'b1;
        end
      end
    end
  end

  // Display: accept a DDR write only when ready; the ack frees the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else if (ddr_wr && dsr_rdy) begin
      disp_valid <= 1'b1;
      disp_data  <= wdata;
    end else if (disp_ack && disp_valid) begin
      disp_valid <= 1'b0;
    end
  end

  // Read mux over the device registers; unmapped I/O reads as zero.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves rdata unassigned and infers a latch.
    rdata = '0;
    case (addr)
      KBSR_ADDR: rdata = {kb_full, kb_ovr, 14'b0};
      KBDR_ADDR: rdata = {8'b0, kbdr};
      DSR_ADDR:  rdata = {dsr_rdy, 15'b0};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: turns a one-cycle MAR/MDR request into a RAM
// access with fixed wait states or an I/O register access, then pulses R.
module lc3_mem_ctrl
  import lc3_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter word_t       IO_BASE     = IO_BASE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  word_t      addr,
  input  word_t      wdata,
  output word_t      rdata,
  output logic       ready,
  output logic       mem_en,
  output logic       mem_we,
  output word_t      mem_addr,
  output word_t      mem_wdata,
  input  word_t      mem_rdata,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  input  logic       disp_ack
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  word_t      addr_q;
  word_t      wdata_q;
  logic       we_q;
  word_t      io_rdata;
  logic       io_rd;
  logic       io_wr;

  // Access FSM state register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: requests are only looked at in IDLE, never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (addr < IO_BASE) ? ACCESS : IO;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      IO:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request and run the wait-state counter down during ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == IDLE && req) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= we;
      cnt_q   <= WS;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Read result: RAM data in the last ACCESS cycle, device data in IO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (!we_q) begin
      if (state_q == ACCESS && cnt_q == '0) rdata <= mem_rdata;
      else if (state_q == IO)               rdata <= io_rdata;
    end
  end

  assign io_rd     = (state_q == IO) && !we_q;
  assign io_wr     = (state_q == IO) && we_q;
  assign ready     = (state_q == DONE);
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  lc3_io_regs u_io_regs (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (io_rd),
    .wr_en      (io_wr),
    .addr       (addr_q),
    .wdata      (wdata_q[7:0]),
    .rdata      (io_rdata),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ack   (disp_ack)
  );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: the driver predicts each access from a
// behavioural model of RAM and the I/O devices, a monitor checks on ready.
module tb_lc3_mem_ctrl;

  localparam int WS = 2;
  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  logic        clk = 1'b0;
  logic        reset;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ready;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack = 1'b0;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.WAIT_STATES(WS), .IO_BASE(16'hFE00)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_ack(disp_ack)
  );

  typedef struct {
    bit          ram;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          en_cnt = 0;

  // Environment RAM (driven by the DUT bus) and the reference memory model.
  logic [15:0] env_ram[256];
  logic [15:0] ref_mem[256];

  // Reference device model.
  logic [15:0] last_rdata = '0;
  bit          kb_full = 1'b0;
  bit          kb_ovr = 1'b0;
  logic [7:0]  kbdr = '0;
  bit          pending = 1'b0;
  logic [7:0]  ddr = '0;

  assign mem_rdata = (mem_en && !mem_we) ? env_ram[mem_addr[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) env_ram[mem_addr[7:0]] = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] io_model(input logic [15:0] a);
    case (a)
      KBSR:    return {kb_full, kb_ovr, 14'b0};
      KBDR:    return {8'h00, kbdr};
      DSR:     return {~pending, 15'b0};
      default: return 16'h0000;
    endcase
  endfunction

  // Monitor: checks the RAM bus during ACCESS and the result on each ready.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mem_en) begin
      en_cnt++;
      check("mem_en_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        check("mem_addr", mem_addr, sb[0].addr);
        check("mem_we", mem_we, sb[0].we);
        if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
      end
    end
    if (ready) begin
      check("ready_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rdata", rdata, e.rdata);
        check("ready_cycle", cyc, e.cyc);
        check("mem_en_cycles", en_cnt, e.ram ? WS + 1 : 0);
      end
      en_cnt = 0;
      done_cnt++;
    end
  end

  // Predict one access, drive it, and wait (bounded) for its ready pulse.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int hold, input bit coinc, input logic [7:0] ch);
    exp_t e;
    int   start;
    e.ram = (a < 16'hFE00);
    e.we = w;
    e.addr = a;
    e.wdata = d;
    if (e.ram) begin
      if (w) ref_mem[a[7:0]] = d;
      else   last_rdata = ref_mem[a[7:0]];
    end else if (!w) begin
      last_rdata = io_model(a);
      if (a == KBDR) begin
        kb_full = 1'b0;
        kb_ovr = 1'b0;
      end
    end else if (a == DDR && !pending) begin
      pending = 1'b1;
      ddr = d[7:0];
    end
    if (coinc) begin
      if (kb_full) kb_ovr = 1'b1;
      else begin
        kbdr = ch;
        kb_full = 1'b1;
      end
    end
    e.rdata = last_rdata;
    e.cyc = cyc + (e.ram ? WS + 2 : 2);
    start = done_cnt;
    sb.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (coinc) begin
      kb_valid = 1'b1;
      kb_data = ch;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    req = 1'b0;
    if (coinc) begin
      @(posedge clk); #1;
      kb_valid = 1'b0;
    end
    for (int i = 0; i < 40 && done_cnt == start; i++) @(posedge clk);
    #1;
    check("ready_seen", done_cnt - start, 1);
    if (done_cnt == start) sb.delete();
  endtask

  task automatic rd(input logic [15:0] a);
    issue(1'b0, a, 16'h0, 0, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    issue(1'b1, a, d, 0, 1'b0, 8'h0);
  endtask

  task automatic kb_strobe(input logic [7:0] ch);
    if (kb_full) kb_ovr = 1'b1;
    else begin
      kbdr = ch;
      kb_full = 1'b1;
    end
    kb_valid = 1'b1; kb_data = ch;
    @(posedge clk); #1;
    kb_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    pending = 1'b0;
    disp_ack = 1'b1;
    @(posedge clk); #1;
    disp_ack = 1'b0;
  endtask

  task automatic check_disp();
    check("disp_valid", disp_valid, pending);
    if (pending) check("disp_data", disp_data, ddr);
  endtask

  initial begin
    logic [15:0] ioa[6];
    int          op;
    int          hold;
    logic [15:0] a;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      env_ram[i] = ref_mem[i];
    end
    ref_mem[0] = 16'h1234;
    env_ram[0] = 16'h1234;

    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 16'h0);
    check("rst_ready", ready, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_disp_data", disp_data, 8'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // RAM read and write with wait states.
    rd(16'h3000);
    check("t1_rdata", rdata, 16'h1234);
    wr(16'h3001, 16'hBEEF);
    check("t2_rdata_kept", rdata, 16'h1234);
    rd(16'h3001);
    check("t2_readback", rdata, 16'hBEEF);

    // I/O space boundary.
    rd(16'hFDFF);
    rd(16'hFE00);

    // Keyboard overrun and clear-on-read.
    kb_strobe(8'h41);
    kb_strobe(8'h42);
    rd(KBSR);
    check("t3_kbsr_full", rdata, 16'hC000);
    rd(KBDR);
    check("t3_kbdr", rdata, 16'h0041);
    rd(KBSR);
    check("t3_kbsr_clear", rdata, 16'h0000);

    // Display write, dropped second write, acknowledge.
    wr(DDR, 16'h0048);
    check_disp();
    check("t4_disp_data", disp_data, 8'h48);
    rd(DSR);
    check("t4_dsr_busy", rdata, 16'h0000);
    wr(DDR, 16'h0049);
    check("t4_disp_data_kept", disp_data, 8'h48);
    ack_pulse();
    check_disp();
    rd(DSR);
    check("t4_dsr_ready", rdata, 16'h8000);

    // Reset in the middle of a RAM access.
    kb_strobe(8'h55);
    wr(DDR, 16'h0050);
    sb.push_back('{1'b1, 1'b0, 16'h3005, 16'h0, 16'h0, 0});
    req = 1'b1; we = 1'b0; addr = 16'h3005;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("t5_mem_en_before", mem_en, 1'b1);
    reset = 1'b0;
    sb.delete();
    en_cnt = 0;
    kb_full = 1'b0; kb_ovr = 1'b0; kbdr = '0;
    pending = 1'b0; ddr = '0; last_rdata = '0;
    #1;
    check("t5_mem_en_abort", mem_en, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_rdata_rst", rdata, 16'h0);
    check("t5_disp_valid_rst", disp_valid, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    rd(KBSR);
    check("t5_kbsr_rst", rdata, 16'h0000);
    rd(DSR);
    check("t5_dsr_rst", rdata, 16'h8000);
    rd(16'h3000);
    check("t5_after_reset", rdata, 16'h1234);

    // req held through ACCESS; KBDR read coincident with a new char.
    issue(1'b0, 16'h3010, 16'h0, WS + 1, 1'b0, 8'h0);
    issue(1'b1, 16'h3011, 16'h5A5A, WS + 1, 1'b0, 8'h0);
    issue(1'b0, KBSR, 16'h0, 1, 1'b0, 8'h0);
    kb_strobe(8'h61);
    issue(1'b0, KBDR, 16'h0, 0, 1'b1, 8'h62);
    check("t6_old_char", rdata, 16'h0061);
    rd(KBSR);
    check("t6_kb_full", rdata, 16'h8000);
    rd(KBDR);
    check("t6_new_char", rdata, 16'h0062);

    // Randomized mix against the reference model.
    for (int n = 0; n < 80; n++) begin
      ioa[0] = KBSR; ioa[1] = KBDR; ioa[2] = DSR; ioa[3] = DDR;
      ioa[4] = 16'hFE08 + 16'(2 * $urandom_range(0, 100));
      ioa[5] = 16'hFFFF;
      op = $urandom_range(0, 6);
      d = 16'($urandom);
      case (op)
        0, 1: begin
          a = 16'h3000 + 16'($urandom_range(0, 31));
          hold = $urandom_range(0, 1) ? WS + 1 : 0;
          issue(op == 1, a, d, hold, 1'b0, 8'h0);
        end
        2, 3: begin
          a = ioa[$urandom_range(0, 5)];
          hold = $urandom_range(0, 1);
          issue(op == 3, a, d, hold, 1'b0, 8'h0);
        end
        4: kb_strobe(8'($urandom));
        5: ack_pulse();
        default: check_disp();
      endcase
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
